// File: rtl/timer_bcd_conv.sv
// Sequential shift-add-3 binary-to-BCD converter for the stopwatch count.
// One input bit per clock; the last result is held on bcd_out until the next conversion.
module timer_bcd_conv #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  d_valid,
  input  logic [WIDTH-1:0]      d_in,
  output logic                  busy,
  output logic                  bcd_valid,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

  // The digit count must be able to represent the largest binary input.
  if (pow10(DIGITS) <= MAX_BIN) begin : g_digits_too_small
    $error("timer_bcd_conv: 10**DIGITS must exceed 2**WIDTH-1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]   scratch_q, scratch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [BW-1:0]   out_q, out_d;
  logic [BW-1:0]   adj;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      out_q     <= out_d;
    end
  end

  // Per-digit +3 correction ahead of the shift; digits never carry into each other.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    out_d     = out_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (d_valid) begin
          bin_d     = d_in;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH - 1);
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {scratch_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        out_d   = scratch_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = busy_q;
  assign bcd_valid = valid_q;
  assign bcd_out   = out_q;

endmodule

// File: tb/tb_timer_bcd_conv.sv
// Scoreboard bench for timer_bcd_conv: stimulus queues expected BCD and arrival cycle,
// an independent monitor checks every bcd_valid pulse and that bcd_out is otherwise held.
module tb_timer_bcd_conv;

  typedef struct packed {
    logic [19:0] bcd;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        d_valid = 1'b0;
  logic [15:0] d_in = '0;
  logic        busy;
  logic        bcd_valid;
  logic [19:0] bcd_out;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [31:0] cyc = '0;
  exp_t        q[$];

  logic        prev_valid = 1'b0;
  logic [19:0] prev_out = '0;

  timer_bcd_conv #(.WIDTH(16), .DIGITS(5)) dut (
    .clock    (clk),
    .reset    (rst_n),
    .d_valid  (d_valid),
    .d_in     (d_in),
    .busy     (busy),
    .bcd_valid(bcd_valid),
    .bcd_out  (bcd_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Monitor: every pulse must match the queue head in value and cycle; otherwise hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_out   = bcd_out;
    end else begin
      if (bcd_valid) begin
        checks++;
        if (prev_valid) begin
          failures++;
          $display("FAIL double_valid: bcd_valid high two cycles, cyc=%0d", cyc);
        end
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid: got bcd_out=%05h with empty queue, cyc=%0d", bcd_out, cyc);
        end else begin
          e = q.pop_front();
          if (bcd_out !== e.bcd) begin
            failures++;
            $display("FAIL bcd_value: got %05h expected %05h", bcd_out, e.bcd);
          end
          checks++;
          if (cyc !== e.cyc) begin
            failures++;
            $display("FAIL latency: valid at cyc %0d expected cyc %0d", cyc, e.cyc);
          end
        end
      end else begin
        checks++;
        if (bcd_out !== prev_out) begin
          failures++;
          $display("FAIL hold: bcd_out changed %05h -> %05h without valid", prev_out, bcd_out);
        end
      end
      prev_valid = bcd_valid;
      prev_out   = bcd_out;
    end
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  // One capture, busy checked for the 17 cycles that follow and cleared afterwards.
  task automatic convert(input logic [15:0] v, input logic [19:0] e);
    exp_t x;
    @(negedge clk);
    d_valid = 1'b1;
    d_in    = v;
    @(posedge clk);
    #1;
    x.bcd = e;
    x.cyc = cyc + 32'd17;
    q.push_back(x);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      d_valid = 1'($urandom);
      d_in    = 16'($urandom);
      check_bit("busy_during", busy, 1'b1);
    end
    @(negedge clk);
    d_valid = 1'b0;
    check_bit("busy_after", busy, 1'b0);
  endtask

  initial begin
    exp_t x;
    logic [31:0] c;
    int unsigned waited;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d_valid = 1'($urandom);
      d_in    = 16'($urandom);
      #1;
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_valid", bcd_valid, 1'b0);
      check_vec("rst_out", bcd_out, 20'h00000);
    end
    @(negedge clk);
    d_valid = 1'b0;
    rst_n   = 1'b1;

    convert(16'd0,     20'h00000);
    convert(16'd65535, 20'h65535);
    convert(16'd1234,  20'h01234);
    convert(16'd9,     20'h00009);
    convert(16'd10,    20'h00010);
    convert(16'd99,    20'h00099);
    convert(16'd100,   20'h00100);
    convert(16'd9999,  20'h09999);
    convert(16'd10000, 20'h10000);
    convert(16'd10000, 20'h10000);

    // d_valid held with d_in counting every cycle: captures every 18 cycles.
    @(negedge clk);
    c = cyc;
    x.bcd = 20'h00000; x.cyc = c + 32'd18; q.push_back(x);
    x.bcd = 20'h00018; x.cyc = c + 32'd36; q.push_back(x);
    x.bcd = 20'h00036; x.cyc = c + 32'd54; q.push_back(x);
    for (int k = 0; k < 54; k++) begin
      if (k != 0) @(negedge clk);
      d_valid = 1'b1;
      d_in    = 16'(k);
    end
    @(negedge clk);
    d_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Abort mid-conversion with reset; no pulse may appear for 4321.
    @(negedge clk);
    d_valid = 1'b1;
    d_in    = 16'd4321;
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("abort_out", bcd_out, 20'h00000);
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_valid", bcd_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_vec("abort_hold", bcd_out, 20'h00000);
    convert(16'd77, 20'h00077);

    waited = 0;
    while (q.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected results never arrived", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
